// File: rtl/encode_riscv_pkg.sv
// encode_riscv_pkg: uop opcode enum, RISC-V opcode/CSR constants and field helpers,
// shared by encode_riscv and the co-simulation checker.
package encode_riscv_pkg;
  localparam int M_WIDTH = 64;
  typedef enum logic [5:0] {
    OP_ADDU, OP_SUBU, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
    OP_SB, OP_SH, OP_SW, OP_SD,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_J, OP_JAL, OP_JR, OP_RET, OP_JALR, OP_LUI, OP_AUIPC,
    OP_NOP, OP_BREAK, OP_MONITOR,
    OP_RDCYCLE, OP_RDINSTRET, OP_RDBRANCH, OP_RDCYCLEH, OP_RDINSTRETH, OP_RDFAULTEDBRANCH,
    OP_II
  } opcode_t;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_J, FMT_U, FMT_NONE} fmt_t;
  localparam logic [6:0] OPC_OP = 7'h33, OPC_OP_IMM = 7'h13, OPC_LOAD = 7'h03, OPC_STORE = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63, OPC_JAL = 7'h6f, OPC_JALR = 7'h67;
  localparam logic [6:0] OPC_LUI = 7'h37, OPC_AUIPC = 7'h17, OPC_SYSTEM = 7'h73;
  localparam logic [11:0] CSR_CYCLE = 12'hc00, CSR_INSTRET = 12'hc02, CSR_BRANCH = 12'hc03;
  localparam logic [11:0] CSR_CYCLEH = 12'hc80, CSR_INSTRETH = 12'hc82, CSR_FAULTEDBRANCH = 12'hc04;

  // decode hands these ops a pc-relative target instead of an offset
  function automatic logic pc_rel(input opcode_t op);
    return op inside {[OP_BEQ:OP_BGEU], OP_J, OP_JAL, OP_AUIPC};
  endfunction

  function automatic logic [2:0] funct3(input opcode_t op);
    case (op)
      OP_SLL, OP_MULH, OP_SLLI, OP_LH, OP_SH, OP_BNE: return 3'd1;
      OP_SLT, OP_MULHSU, OP_SLTI, OP_LW, OP_SW, OP_RDCYCLE, OP_RDINSTRET, OP_RDBRANCH,
      OP_RDCYCLEH, OP_RDINSTRETH, OP_RDFAULTEDBRANCH: return 3'd2;
      OP_SLTU, OP_MULHU, OP_SLTIU, OP_LD, OP_SD: return 3'd3;
      OP_XOR, OP_DIV, OP_XORI, OP_LBU, OP_BLT: return 3'd4;
      OP_SRL, OP_SRA, OP_DIVU, OP_SRLI, OP_SRAI, OP_LHU, OP_BGE: return 3'd5;
      OP_OR, OP_REM, OP_ORI, OP_LWU, OP_BLTU: return 3'd6;
      OP_AND, OP_REMU, OP_ANDI, OP_BGEU: return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [11:0] csr_addr(input opcode_t op);
    return op == OP_RDCYCLE ? CSR_CYCLE : op == OP_RDINSTRET ? CSR_INSTRET :
           op == OP_RDBRANCH ? CSR_BRANCH : op == OP_RDCYCLEH ? CSR_CYCLEH :
           op == OP_RDINSTRETH ? CSR_INSTRETH : CSR_FAULTEDBRANCH;
  endfunction

  function automatic logic fits_signed(input logic [M_WIDTH-1:0] v, input int unsigned n);
    logic [M_WIDTH-1:0] s;
    s = M_WIDTH'($signed(v) >>> (n - 1));
    return s == '0 || s == '1;
  endfunction
endpackage

// File: rtl/encode_riscv_if.sv
// encode_riscv_if: uop input stream, trace record output stream and status of encode_riscv.
interface encode_riscv_if;
  import encode_riscv_pkg::*;
  logic mode64;
  logic in_valid, in_ready;
  opcode_t in_op;
  logic [4:0] in_rd, in_rs1, in_rs2;
  logic [M_WIDTH-1:0] in_imm, in_pc;
  logic out_valid, out_ready, out_unenc;
  logic [M_WIDTH-1:0] out_pc;
  logic [31:0] out_insn, unenc_count;
  modport slave (
    input mode64, in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_insn, out_unenc, unenc_count
  );
  modport master (
    output mode64, in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_pc, out_ready,
    input in_ready, out_valid, out_pc, out_insn, out_unenc, unenc_count
  );
endinterface

// File: rtl/encode_riscv_trace_fifo.sv
// encode_riscv_trace_fifo: valid/ready FIFO with wrap-bit pointers and occupancy count;
// when empty the output shows the last popped entry.
module encode_riscv_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [AW:0]      count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic [AW-1:0] rd_idx;

  assign count_o = wr_q - rd_q;
  assign valid_o = wr_q != rd_q;
  assign rd_idx = valid_o ? rd_q[AW-1:0] : rd_q[AW-1:0] - AW'(1);
  assign data_o = mem_q[rd_idx];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + (AW+1)'(1);
      if (pop_i && valid_o) rd_q <= rd_q + (AW+1)'(1);
    end
    if (push_i && !rst_i) mem_q[wr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/encode_riscv.sv
// encode_riscv: re-encodes retired uops into RV32/RV64 base+M words behind a credit-gated trace FIFO.
// Define ENCODE_TRACE_RANGE_CHECK_EN to flag offsets that do not fit their immediate field.
module encode_riscv
  import encode_riscv_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           reset,
  encode_riscv_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH);
  localparam int RW = M_WIDTH + 33;
  logic e0_valid_q, mode64_q, accept, range_ok, unenc;
  opcode_t op_q;
  logic [4:0] rd_q, rs1_q, rs2_q, rd_e, rs1_e;
  logic [M_WIDTH-1:0] pc_q, off_q, off_d, diff;
  logic [CW:0] count;
  fmt_t fmt;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [11:0] imm_i;
  logic [5:0] shamt;
  logic [31:0] insn, unenc_count_q;
  logic [RW-1:0] rec_out;

  // credit from registered state only, so out_ready never reaches in_ready combinationally
  assign bus.in_ready = !reset && (int'(count) + int'(e0_valid_q) < FIFO_DEPTH);
  assign accept = bus.in_valid && bus.in_ready;
  assign diff = bus.in_imm - bus.in_pc;
  assign off_d = !pc_rel(bus.in_op) ? bus.in_imm :
                 bus.mode64 ? diff : {{32{diff[31]}}, diff[31:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      e0_valid_q <= 1'b0;
      unenc_count_q <= '0;
    end else begin
      e0_valid_q <= accept;
      if (e0_valid_q && unenc && unenc_count_q != '1) unenc_count_q <= unenc_count_q + 32'd1;
    end
    if (accept) begin
      op_q <= bus.in_op;
      rd_q <= bus.in_rd;
      rs1_q <= bus.in_rs1;
      rs2_q <= bus.in_rs2;
      pc_q <= bus.in_pc;
      off_q <= off_d;
      mode64_q <= bus.mode64;
    end
  end

  assign f3 = funct3(op_q);
  assign f7 = op_q inside {OP_SUBU, OP_SRA, OP_SRAI} ? 7'h20 :
              op_q inside {[OP_MUL:OP_REMU]} ? 7'h01 : 7'h00;
  assign shamt = mode64_q ? off_q[5:0] : {1'b0, off_q[4:0]};

  always_comb begin
    fmt = FMT_I;
    opc = OPC_OP_IMM;
    rd_e = rd_q;
    rs1_e = rs1_q;
    imm_i = off_q[11:0];
    if (op_q inside {[OP_ADDU:OP_REMU]}) begin
      fmt = FMT_R;
      opc = OPC_OP;
    end else if (op_q inside {[OP_SLLI:OP_SRAI]}) imm_i = {f7, 5'd0} | {6'd0, shamt};
    else if (op_q inside {[OP_LB:OP_LWU]}) opc = OPC_LOAD;
    else if (op_q inside {[OP_SB:OP_SD]}) begin
      fmt = FMT_S;
      opc = OPC_STORE;
    end else if (op_q inside {[OP_BEQ:OP_BGEU]}) begin
      fmt = FMT_B;
      opc = OPC_BRANCH;
    end else if (op_q inside {OP_J, OP_JAL}) begin
      fmt = FMT_J;
      opc = OPC_JAL;
      rd_e = op_q == OP_J ? 5'd0 : rd_q;
    end else if (op_q inside {[OP_JR:OP_JALR]}) begin
      opc = OPC_JALR;
      rd_e = op_q == OP_JALR ? rd_q : 5'd0;
    end else if (op_q inside {OP_LUI, OP_AUIPC}) begin
      fmt = FMT_U;
      opc = op_q == OP_LUI ? OPC_LUI : OPC_AUIPC;
    end else if (op_q inside {[OP_NOP:OP_MONITOR]}) begin
      opc = op_q == OP_NOP ? OPC_OP_IMM : OPC_SYSTEM;
      rd_e = 5'd0;
      rs1_e = 5'd0;
      imm_i = {11'd0, op_q == OP_MONITOR};
    end else if (op_q inside {[OP_RDCYCLE:OP_RDFAULTEDBRANCH]}) begin
      opc = OPC_SYSTEM;
      rs1_e = 5'd0;
      imm_i = csr_addr(op_q);
    end else if (!(op_q inside {[OP_ADDI:OP_ANDI]})) fmt = FMT_NONE;
  end

  assign insn = fmt == FMT_R ? {f7, rs2_q, rs1_q, f3, rd_q, opc} :
                fmt == FMT_S ? {off_q[11:5], rs2_q, rs1_q, f3, off_q[4:0], opc} :
                fmt == FMT_B ? {off_q[12], off_q[10:5], rs2_q, rs1_q, f3, off_q[4:1], off_q[11], opc} :
                fmt == FMT_J ? {off_q[20], off_q[10:1], off_q[11], off_q[19:12], rd_e, opc} :
                fmt == FMT_U ? {off_q[31:12], rd_q, opc} :
                fmt == FMT_I ? {imm_i, rs1_e, f3, rd_e, opc} : 32'd0;

`ifdef ENCODE_TRACE_RANGE_CHECK_EN
  logic imm_off;
  assign imm_off = op_q inside {[OP_ADDI:OP_ANDI], [OP_LB:OP_LWU], [OP_JR:OP_JALR]};
  assign range_ok = fmt == FMT_B ? fits_signed(off_q, 13) && !off_q[0] :
                    fmt == FMT_J ? fits_signed(off_q, 21) && !off_q[0] :
                    fmt == FMT_S || imm_off ? fits_signed(off_q, 12) : 1'b1;
  a_range: assert property (@(posedge clk) disable iff (reset) e0_valid_q |-> range_ok);
`else
  logic unused_off;
  assign unused_off = ^off_q[M_WIDTH-1:32];
  assign range_ok = 1'b1;
`endif

  assign unenc = fmt == FMT_NONE || !range_ok;

  encode_riscv_trace_fifo #(.WIDTH(RW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i(clk),
    .rst_i(reset),
    .push_i(e0_valid_q),
    .data_i({pc_q, unenc ? 32'd0 : insn, unenc}),
    .pop_i(bus.out_ready),
    .valid_o(bus.out_valid),
    .data_o(rec_out),
    .count_o(count)
  );

  assign bus.out_pc = rec_out[RW-1:33];
  assign bus.out_insn = rec_out[32:1];
  assign bus.out_unenc = rec_out[0];
  assign bus.unenc_count = unenc_count_q;
endmodule

// File: tb/tb_encode_riscv.sv
// tb_encode_riscv: directed vectors with hand-computed encodings, credit/fill and reset checks.
module tb_encode_riscv;
  import encode_riscv_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  encode_riscv_if bus();

  encode_riscv #(.FIFO_DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input opcode_t op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [63:0] imm, input logic [63:0] pc);
    bus.in_op = op;
    bus.in_rd = rd;
    bus.in_rs1 = rs1;
    bus.in_rs2 = rs2;
    bus.in_imm = imm;
    bus.in_pc = pc;
  endtask

  task automatic send(input string tag, input opcode_t op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [63:0] imm, input logic [63:0] pc);
    int w;
    w = 0;
    @(negedge clk);
    drive(op, rd, rs1, rs2, imm, pc);
    bus.in_valid = 1'b1;
    while (!bus.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic vec(input string tag, input opcode_t op, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [63:0] imm, input logic [63:0] pc,
                     input logic [31:0] exp_insn, input logic exp_unenc);
    send(tag, op, rd, rs1, rs2, imm, pc);
    @(negedge clk);
    check({tag, " latency"}, 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check({tag, " out_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, " insn"}, 64'(bus.out_insn), 64'(exp_insn));
    check({tag, " unenc"}, 64'(bus.out_unenc), 64'(exp_unenc));
    check({tag, " pc"}, bus.out_pc, pc);
  endtask

  function automatic logic [31:0] addi_word(input int i);
    return (32'(i) << 20) | (32'(i) << 7) | 32'h13;
  endfunction

  initial begin
    int acc;
    logic rdy;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.mode64 = 1'b1;
    drive(OP_NOP, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", 64'(bus.in_ready), 64'd0);
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset unenc_count", 64'(bus.unenc_count), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("release in_ready", 64'(bus.in_ready), 64'd1);

    vec("ADDI", OP_ADDI, 5'd1, 5'd0, 5'd0, 64'd5, 64'h100, 32'h00500093, 1'b0);
    vec("BEQ", OP_BEQ, 5'd0, 5'd1, 5'd2, 64'h1008, 64'h1000, 32'h00208463, 1'b0);
    vec("JAL", OP_JAL, 5'd1, 5'd0, 5'd0, 64'h2010, 64'h2000, 32'h010000EF, 1'b0);
    vec("LUI", OP_LUI, 5'd5, 5'd0, 5'd0, 64'h12345000, 64'h2004, 32'h123452B7, 1'b0);
    vec("RET", OP_RET, 5'd0, 5'd1, 5'd0, 64'd0, 64'h2008, 32'h00008067, 1'b0);
    vec("RDCYCLE", OP_RDCYCLE, 5'd3, 5'd0, 5'd0, 64'd0, 64'h200c, 32'hC00021F3, 1'b0);
    vec("SUBU", OP_SUBU, 5'd3, 5'd4, 5'd5, 64'd0, 64'h2010, 32'h405201B3, 1'b0);
    vec("MUL", OP_MUL, 5'd1, 5'd2, 5'd3, 64'd0, 64'h2014, 32'h023100B3, 1'b0);
    vec("SRAI64", OP_SRAI, 5'd1, 5'd2, 5'd0, 64'd33, 64'h2018, 32'h42115093, 1'b0);
    vec("SW", OP_SW, 5'd0, 5'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFC, 64'h201c, 32'hFE312E23, 1'b0);
    vec("LD", OP_LD, 5'd4, 5'd5, 5'd0, 64'd8, 64'h2020, 32'h0082B203, 1'b0);
    vec("JALR", OP_JALR, 5'd1, 5'd5, 5'd0, 64'd4, 64'h2024, 32'h004280E7, 1'b0);
    vec("AUIPC", OP_AUIPC, 5'd2, 5'd0, 5'd0, 64'h5000, 64'h1000, 32'h00004117, 1'b0);
    vec("MONITOR", OP_MONITOR, 5'd0, 5'd0, 5'd0, 64'd0, 64'h2028, 32'h00100073, 1'b0);
    vec("NOP", OP_NOP, 5'd7, 5'd7, 5'd0, 64'd9, 64'h202c, 32'h00000013, 1'b0);
    vec("II", OP_II, 5'd1, 5'd2, 5'd3, 64'd0, 64'h2030, 32'h0, 1'b1);
    check("II unenc_count", 64'(bus.unenc_count), 64'd1);

    bus.mode64 = 1'b0;
    vec("SRAI32", OP_SRAI, 5'd1, 5'd2, 5'd0, 64'd35, 64'h2034, 32'h40315093, 1'b0);
    vec("BNE32 back", OP_BNE, 5'd0, 5'd1, 5'd0, 64'hDEAD_BEEF_8000_0000, 64'h8000_0010, 32'hFE0098E3, 1'b0);
    bus.mode64 = 1'b1;

    @(negedge clk);
    bus.out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      drive(OP_ADDI, 5'(acc + 1), 5'd0, 5'd0, 64'(acc + 1), 64'h3000 + 64'(4 * acc));
      bus.in_valid = 1'b1;
      rdy = bus.in_ready;
      @(posedge clk);
      if (rdy) acc++;
    end
    #1 bus.in_valid = 1'b0;
    check("fill accepted", 64'(acc), 64'd4);
    @(negedge clk);
    check("full in_ready", 64'(bus.in_ready), 64'd0);
    check("full head held", 64'(bus.out_insn), 64'(addi_word(1)));
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain out_valid", 64'(bus.out_valid), 64'd1);
      check("drain order", 64'(bus.out_insn), 64'(addi_word(k + 1)));
      @(negedge clk);
    end
    check("drained out_valid", 64'(bus.out_valid), 64'd0);
    check("empty holds insn", 64'(bus.out_insn), 64'(addi_word(4)));

    bus.out_ready = 1'b0;
    send("pre-rst a", OP_ADDI, 5'd1, 5'd0, 5'd0, 64'd1, 64'h4000);
    send("pre-rst b", OP_II, 5'd0, 5'd0, 5'd0, 64'd0, 64'h4004);
    send("pre-rst c", OP_ADDI, 5'd2, 5'd0, 5'd0, 64'd2, 64'h4008);
    repeat (2) @(negedge clk);
    check("pre-rst out_valid", 64'(bus.out_valid), 64'd1);
    check("pre-rst unenc_count", 64'(bus.unenc_count), 64'd2);
    reset = 1'b1;
    @(negedge clk);
    check("mid-rst out_valid", 64'(bus.out_valid), 64'd0);
    check("mid-rst unenc_count", 64'(bus.unenc_count), 64'd0);
    check("mid-rst in_ready", 64'(bus.in_ready), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post-rst in_ready", 64'(bus.in_ready), 64'd1);
    check("post-rst out_valid", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b1;
    vec("post-rst ADDI", OP_ADDI, 5'd1, 5'd0, 5'd0, 64'd5, 64'h5000, 32'h00500093, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/encode_riscv.md
# encode_riscv

Re-encodes decoded uops (op, architectural register indices, immediate, pc) back into 32-bit RV32/RV64 base+M instruction words for the commit trace port and the co-simulation checker. It sits beside the retire path, consumes a valid/ready uop stream and produces a buffered valid/ready stream of {pc, insn, unencodable} records. Branch, JAL and AUIPC immediates arrive as pc-relative targets, matching what decode emits, so the block recovers the offset by subtraction.

## Interface
- FIFO_DEPTH, 4: output buffer entries, power of two, >=2
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- mode64  in  1  1 = RV64 arithmetic for offset recovery, 0 = RV32 (low 32 bits)
- in_valid  in  1  uop record valid
- in_ready  out  1  block accepts record this cycle
- in_op  in  opcode_t  uop op enum
- in_rd / in_rs1 / in_rs2  in  5 each  architectural register indices
- in_imm  in  `M_WIDTH  uop rvimm
- in_pc  in  `M_WIDTH  uop pc
- out_valid  out  1  record available
- out_ready  in  1  sink consumes record
- out_pc  out  `M_WIDTH  pc of record
- out_insn  out  32  encoded word
- out_unenc  out  1  op has no encoding; out_insn = 0
- unenc_count  out  32  saturating count of unencodable records accepted

## Operation
- Stage E0 (register): on in_valid&in_ready latch op, regs, pc, and offset = in_imm - in_pc for BEQ..BGEU, J, JAL, AUIPC; else offset = in_imm. With mode64=0 subtract on low 32 bits.
- Stage E1 (comb from E0, writes FIFO): field assembly per op class: R-type (ADDU,SUBU,SLL..AND,MUL..REMU: opcode 0x33, funct7 0x00/0x01/0x20); I-type ALU/loads (0x13/0x03, imm = offset[11:0]; SLLI/SRLI/SRAI use shamt offset[5:0] in RV64, [4:0] in RV32, funct7 0x20 for SRAI); S-type 0x23; B-type 0x63; J-type 0x6f; U-type LUI 0x37 / AUIPC 0x17 using offset[31:12].
- JR/RET encode as jalr x0, imm(rs1); JALR as jalr rd, imm(rs1).
- NOP -> 0x00000013; BREAK -> 0x00000073; MONITOR -> 0x00100073; RDCYCLE/RDINSTRET/RDBRANCH -> csrrs rd, 0xc00/0xc02/0xc03, x0; RDCYCLEH/RDINSTRETH/RDFAULTEDBRANCH -> 0xc80/0xc82/0xc04.
- Any other op (incl. II): out_insn = 0, out_unenc = 1, unenc_count increments (saturates at 0xffffffff).
- FIFO: FIFO_DEPTH entries, wrap-around read/write pointers with extra wrap bit.

## Timing
- Reset: in_ready=0 during reset cycle then 1; out_valid=0; unenc_count=0; FIFO and E0 empty. Reset mid-operation drops all in-flight records.
- Latency: record accepted cycle N -> out_valid cycle N+2 (FIFO empty, out_ready irrelevant).
- Credit rule: in_ready = (fifo_count + e0_valid) < FIFO_DEPTH; no overflow is possible, E0 never stalls.
- out_* stable while out_valid & !out_ready.
- Simultaneous push and pop when full: pop frees slot; in_ready reflects count registered at cycle start (no combinational out_ready->in_ready path).
- Empty: out_valid=0, out_pc/out_insn hold last value.

## Configuration
- ENCODE_TRACE_RANGE_CHECK_EN defined: E1 additionally checks offset fits its field (B: 13-bit signed, even; J: 21-bit signed, even; I/S: 12-bit signed); failure forces out_unenc=1, out_insn=0, counts in unenc_count, and fires a simulation assertion.
- Undefined: no check; field bits truncated silently.

## Structure
- opcode_t, uop field widths from existing uop.vh; RV opcode/funct localparams (OPC_OP, OPC_OP_IMM, OPC_BRANCH, CSR addresses) go in a shared riscv_enc package for reuse by the checker.
- Sub-module: trace_fifo (parameterized valid/ready FIFO with count output).

## Test plan
- ADDI rd=1 rs1=0 imm=5 -> out_insn 0x00500093, out_valid at N+2.
- BEQ rs1=1 rs2=2 pc=0x1000 imm=0x1008 -> 0x00208463; JAL rd=1 pc=0x2000 imm=0x2010 -> 0x010000EF.
- LUI rd=5 imm=0x12345000 -> 0x123452B7; RET rs1=1 -> 0x00008067; RDCYCLE rd=3 -> 0xC00021F3.
- out_ready=0, offer 8 back-to-back records -> exactly FIFO_DEPTH accepted, in_ready low thereafter; release out_ready -> records emerge in order, one per cycle.
- op=II -> out_unenc=1, out_insn=0, unenc_count=1; with ENCODE_TRACE_RANGE_CHECK_EN, BEQ offset 0x2000 -> out_unenc=1.
- reset asserted with 3 records buffered -> next cycle out_valid=0, unenc_count=0, in_ready=1 cycle after release.
